// File: rtl/serkey_seq_ctrl.sv
// Serial key/ID GAL sequencer: win the local bus, clock the GAL through its unlock nibbles, then shift out NBITS of key data.
// Optional SERKEY_PARITY_EN adds one trailing even-parity access that must match before data is published.
module serkey_seq_ctrl #(
  parameter int                   KEY_LEN     = 4,
  parameter logic [4*KEY_LEN-1:0] KEY         = 16'h9A5C,
  parameter int                   NBITS       = 16,
  parameter logic [3:0]           RD_NIB      = 4'h0,
  parameter int                   GNT_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NBITS-1:0] data,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [13:0]      ba,
  output logic             br_w,
  output logic             sser_n,
  output logic             acc_clk,
  input  logic             sdrd
);

`ifdef SERKEY_PARITY_EN
  localparam int PAR_ACC = 1;
`else
  localparam int PAR_ACC = 0;
`endif
  localparam int N_ACC = KEY_LEN + NBITS + PAR_ACC;
  localparam int AW    = $clog2(N_ACC + 1);
  localparam int WW    = $clog2(GNT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_SETUP, S_STROBE, S_SAMPLE, S_FIN, S_FAIL
  } state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    acc_cnt;
  logic [WW-1:0]    wait_cnt;
  logic [NBITS-1:0] stage;
  logic [3:0]       key_nib;
  logic             data_phase;
  logic             last_acc;
  logic             par_acc;
  logic             par_bad;

  assign data_phase = (acc_cnt >= AW'(KEY_LEN));
  assign last_acc   = (acc_cnt == AW'(N_ACC - 1));
`ifdef SERKEY_PARITY_EN
  assign par_acc    = (acc_cnt == AW'(KEY_LEN + NBITS));
  assign par_bad    = par_acc && (sdrd != ^stage);
`else
  assign par_acc    = 1'b0;
  assign par_bad    = 1'b0;
`endif

  always_comb begin
    key_nib = '0;
    for (int i = 0; i < KEY_LEN; i++) begin
      if (acc_cnt == AW'(i)) key_nib = KEY[4*i +: 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    bus_req   = 1'b0;
    ba        = '0;
    br_w      = 1'b0;
    sser_n    = 1'b1;
    acc_clk   = 1'b0;
    if (state == S_SETUP || state == S_STROBE || state == S_SAMPLE) begin
      bus_req = 1'b1;
      busy    = 1'b1;
      br_w    = 1'b1;
      sser_n  = 1'b0;
      ba      = {2'b01, 4'b0000, (data_phase ? RD_NIB : key_nib), 4'b0000};
    end
    case (state)
      S_IDLE: if (start) state_nxt = S_REQ;
      S_REQ: begin
        busy    = 1'b1;
        bus_req = 1'b1;
        if (bus_gnt)                             state_nxt = S_SETUP;
        else if (wait_cnt == WW'(GNT_TIMEOUT-1)) state_nxt = S_FAIL;
      end
      S_SETUP:  state_nxt = bus_gnt ? S_STROBE : S_FAIL;
      S_STROBE: begin
        acc_clk   = 1'b1;
        state_nxt = bus_gnt ? S_SAMPLE : S_FAIL;
      end
      S_SAMPLE: begin
        if (!bus_gnt || par_bad) state_nxt = S_FAIL;
        else if (last_acc)       state_nxt = S_FIN;
        else                     state_nxt = S_SETUP;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_FAIL: begin
        err       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Data bits shift in from the top so the first bit read lands in bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt  <= '0;
      wait_cnt <= '0;
      stage    <= '0;
      data     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          acc_cnt  <= '0;
          wait_cnt <= '0;
          if (start) stage <= '0;
        end
        S_REQ: wait_cnt <= bus_gnt ? '0 : wait_cnt + WW'(1);
        S_SAMPLE: begin
          if (data_phase && !par_acc) stage <= {sdrd, stage[NBITS-1:1]};
          acc_cnt <= acc_cnt + AW'(1);
        end
        S_FIN: begin
          data    <= stage;
          acc_cnt <= '0;
        end
        S_FAIL: begin
          acc_cnt  <= '0;
          wait_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
